// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin merge of valid/ready streams, grant locked per packet, registered output
module stream_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [SEL_WIDTH-1:0]             out_sel,
  output logic                             out_valid,
  input  logic                             out_ready
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick;
  logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic out_last_q, out_last_d, out_valid_q, out_valid_d, accept;
  // descending scan so the requester closest to rr_ptr overrides the rest
  always_comb begin
    int idx;
    idx = 0;
    pick = rr_ptr_q;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      idx = idx >= NUM_INPUTS ? idx - NUM_INPUTS : idx;
      if (in_valid[idx[SEL_WIDTH-1:0]]) pick = idx[SEL_WIDTH-1:0];
    end
  end
  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED && !reset) in_ready[grant_q] = !out_valid_q || out_ready;
    accept = state_q == LOCKED && in_valid[grant_q] && in_ready[grant_q];
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && |in_valid) begin
      state_d = LOCKED;
      grant_d = pick;
    end
    if (accept && in_last[grant_q]) begin
      state_d = IDLE;
      rr_ptr_d = grant_q == SEL_WIDTH'(NUM_INPUTS - 1) ? '0 : grant_q + 1'b1;
    end
    out_data_d = accept ? in_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : out_data_q;
    out_last_d = accept ? in_last[grant_q] : out_last_q;
    out_sel_d = accept ? grant_q : out_sel_q;
    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_sel_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_sel_q <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_sel = out_sel_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench for the packet-locked round-robin stream arbiter
module tb_stream_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_last, in_valid, in_ready;
  logic [W-1:0] out_data;
  logic out_last, out_valid, out_ready;
  logic [1:0] out_sel;
  int checks = 0;
  int errors = 0;
  logic [W:0] src [N][$];
  logic [W+2:0] sb [$];
  int got_sel [$];
  int got_cyc [$];
  int reset_at = -1;
  int stall_start = -1;
  int stall_len = 0;

  stream_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = src[i].size() > 0;
      in_data[i*W +: W] = src[i].size() > 0 ? src[i][0][W-1:0] : '0;
      in_last[i] = src[i].size() > 0 ? src[i][0][W] : 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input int r, input int n, input int base);
    for (int k = 0; k < n; k++) src[r].push_back({k == n - 1, W'(base + k)});
  endtask

  task automatic run(input int budget);
    int c;
    logic [W-1:0] prev_d;
    logic prev_stall, after_rst, idle;
    logic [W+2:0] exp;
    c = 0;
    prev_d = '0;
    prev_stall = 1'b0;
    after_rst = 1'b0;
    got_sel.delete();
    got_cyc.delete();
    while (c < budget) begin
      reset = c == reset_at;
      out_ready = !(stall_start >= 0 && c >= stall_start && c < stall_start + stall_len);
      drive();
      @(negedge clk);
      if (reset) begin
        sb.delete();
        for (int i = 0; i < N; i++) src[i].delete();
        prev_stall = 1'b0;
        after_rst = 1'b1;
      end else begin
        if (after_rst) begin
          checks++;
          if (out_valid !== 1'b0 || in_ready !== '0)
            $display("FAIL post_reset out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
          if (out_valid !== 1'b0 || in_ready !== '0) errors++;
          after_rst = 1'b0;
        end
        for (int i = 0; i < N; i++)
          if (in_valid[i] && in_ready[i]) begin
            sb.push_back({2'(i), src[i][0]});
            void'(src[i].pop_front());
          end
        if (prev_stall) begin
          checks++;
          if (out_data !== prev_d || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold data=%h valid=%b want %h 1", out_data, out_valid, prev_d);
          end
        end
        if (out_valid && !out_ready) begin
          checks++;
          if (in_ready !== '0) begin
            errors++;
            $display("FAIL stall_in_ready got %b want 0000", in_ready);
          end
        end
        if (out_valid && out_ready) begin
          got_sel.push_back(int'(out_sel));
          got_cyc.push_back(c);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra got sel=%0d data=%h with nothing expected", out_sel, out_data);
          end else begin
            exp = sb.pop_front();
            if ({out_sel, out_last, out_data} !== exp) begin
              errors++;
              $display("FAIL sb_beat got sel=%0d last=%b data=%h want sel=%0d last=%b data=%h",
                       out_sel, out_last, out_data, exp[W+2:W+1], exp[W], exp[W-1:0]);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
      end
      @(posedge clk);
      #1;
      idle = !reset && sb.size() == 0 && !out_valid;
      for (int i = 0; i < N; i++) idle = idle && src[i].size() == 0;
      c++;
      if (idle) break;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL run_timeout got %0d cycles want < %0d", c, budget);
    end
    reset_at = -1;
    stall_start = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = '1;
    in_last = '1;
    in_data = {N{32'hDEAD_BEEF}};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== '0 || out_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset got valid=%b ready=%b sel=%0d want 0 0000 0", out_valid, in_ready, out_sel);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
  endtask

  task automatic test_single_packet();
    do_reset();
    load(2, 3, 'hA0);
    run(50);
    checks++;
    if (got_sel.size() != 3 || got_sel[0] != 2 || got_sel[1] != 2 || got_sel[2] != 2) begin
      errors++;
      $display("FAIL single_sel got n=%0d want 3 beats sel=2", got_sel.size());
    end
    checks++;
    if (got_cyc.size() != 3 || got_cyc[0] != 2 || got_cyc[1] != 3 || got_cyc[2] != 4) begin
      errors++;
      $display("FAIL single_timing got first=%0d want cycles 2,3,4", got_cyc.size() > 0 ? got_cyc[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < N; r++) begin
      load(r, 1, 'h100 + r * 16);
      load(r, 1, 'h108 + r * 16);
    end
    run(100);
    checks++;
    if (got_sel.size() != 2 * N) begin
      errors++;
      $display("FAIL rr_count got %0d want %0d", got_sel.size(), 2 * N);
    end else
      for (int k = 0; k < 2 * N; k++) begin
        checks++;
        if (got_sel[k] != k % N) begin
          errors++;
          $display("FAIL rr_order[%0d] got %0d want %0d", k, got_sel[k], k % N);
        end
        if (k > 0) begin
          checks++;
          if (got_cyc[k] - got_cyc[k-1] != 2) begin
            errors++;
            $display("FAIL rr_gap[%0d] got %0d want 2", k, got_cyc[k] - got_cyc[k-1]);
          end
        end
      end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    load(2, 1, 'h200);
    run(30);
    load(1, 1, 'h210);
    run(30);
    checks++;
    if (got_sel.size() != 1 || got_sel[0] != 1) begin
      errors++;
      $display("FAIL wrap_grant got %0d want 1", got_sel.size() > 0 ? got_sel[0] : -1);
    end
    load(0, 1, 'h220);
    load(3, 1, 'h230);
    run(30);
    checks++;
    if (got_sel.size() != 2 || got_sel[0] != 3 || got_sel[1] != 0) begin
      errors++;
      $display("FAIL skip_grant got first=%0d want 3 then 0", got_sel.size() > 0 ? got_sel[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load(0, 5, 'h10);
    stall_start = 3;
    stall_len = 5;
    run(60);
    checks++;
    if (got_sel.size() != 5 || got_cyc[4] != 11) begin
      errors++;
      $display("FAIL bp_count got %0d beats last_cyc=%0d want 5 beats last_cyc=11",
               got_sel.size(), got_cyc.size() > 0 ? got_cyc[got_cyc.size()-1] : -1);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    load(2, 1, 'h300);
    run(30);
    load(3, 4, 'h310);
    reset_at = 3;
    run(30);
    checks++;
    if (got_sel.size() != 1 || got_sel[0] != 3) begin
      errors++;
      $display("FAIL mid_reset_pre got %0d beats want 1 beat from 3", got_sel.size());
    end
    load(1, 1, 'h320);
    load(3, 1, 'h330);
    run(30);
    checks++;
    if (got_sel.size() != 2 || got_sel[0] != 1 || got_sel[1] != 3) begin
      errors++;
      $display("FAIL mid_reset_grant got first=%0d want 1 then 3", got_sel.size() > 0 ? got_sel[0] : -1);
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wrap_skip();
    test_backpressure();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
